// File: rtl/s2mm_ring_controller.sv
// Burst-granular sequencer for the stream-to-memory writer: walks a DDR ring one burst at a
// time, gates the sample stream so runs start and stop on burst boundaries, and reports progress.
module s2mm_ring_controller #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BURST_LENGTH   = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [15:0]           cfg_burst_count,
  input  logic                  cfg_one_shot,
  input  logic                  cfg_enable,
  input  logic                  beat,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  stream_gate,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           wr_pointer,
  output logic [15:0]           wrap_count
);

  localparam int BW = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam logic [BW-1:0]         LAST_BEAT   = BW'(BURST_LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LENGTH * AXI_DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_e;

  state_e                state_q, state_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [15:0]           burst_idx_q, burst_idx_d;
  logic [15:0]           wrap_count_q, wrap_count_d;
  logic [15:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  one_shot_q, one_shot_d;

  logic counted, burst_end, ring_end;

  // Gate comes straight from the registered state, so the writer never sees a beat-to-gate loop.
  assign stream_gate = (state_q == RUN) || (state_q == FINISH);
  assign busy        = stream_gate;
  assign done        = (state_q == DONE);
  assign address     = address_q;
  assign wr_pointer  = burst_idx_q;
  assign wrap_count  = wrap_count_q;

  assign counted   = beat && stream_gate;
  assign burst_end = counted && (beat_cnt_q == LAST_BEAT);
  assign ring_end  = burst_end && (burst_idx_q == count_q - 16'd1);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    burst_idx_d  = burst_idx_q;
    wrap_count_d = wrap_count_q;
    count_d      = count_q;
    address_d    = address_q;
    base_d       = base_q;
    one_shot_d   = one_shot_q;

    unique case (state_q)
      IDLE: begin
        if (cfg_enable && (cfg_burst_count != 16'd0)) begin
          base_d       = cfg_base;
          count_d      = cfg_burst_count;
          one_shot_d   = cfg_one_shot;
          address_d    = cfg_base;
          beat_cnt_d   = '0;
          burst_idx_d  = '0;
          wrap_count_d = '0;
          state_d      = RUN;
        end
      end

      RUN, FINISH: begin
        if (counted) beat_cnt_d = beat_cnt_q + BW'(1);
        if (ring_end) begin
          burst_idx_d  = '0;
          address_d    = base_q;
          wrap_count_d = wrap_count_q + 16'd1;
        end else if (burst_end) begin
          burst_idx_d = burst_idx_q + 16'd1;
          address_d   = address_q + BURST_BYTES;
        end

        // A one-shot ring end outranks an enable drop arriving in the same cycle.
        if (ring_end && one_shot_q) begin
          state_d = DONE;
        end else if (state_q == RUN) begin
          if (!cfg_enable) begin
            if (burst_end || (beat_cnt_q == '0 && !counted)) state_d = IDLE;
            else                                              state_d = FINISH;
          end
        end else if (burst_end) begin
          state_d = IDLE;
        end
      end

      DONE: begin
        if (!cfg_enable) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (areset) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      burst_idx_q  <= '0;
      wrap_count_q <= '0;
      count_q      <= '0;
      address_q    <= '0;
      base_q       <= '0;
      one_shot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_idx_q  <= burst_idx_d;
      wrap_count_q <= wrap_count_d;
      count_q      <= count_d;
      address_q    <= address_d;
      base_q       <= base_d;
      one_shot_q   <= one_shot_d;
    end
  end

endmodule

// File: tb/tb_s2mm_ring_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared every cycle
// against a beat-counting reference model of the ring.
module tb_s2mm_ring_controller;

  localparam int BL = 16;
  localparam int BB = 64;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] cfg_base;
  logic [15:0] cfg_burst_count;
  logic        cfg_one_shot;
  logic        cfg_enable;
  logic        beat;
  logic [31:0] address;
  logic        stream_gate, busy, done;
  logic [15:0] wr_pointer, wrap_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: progress is a plain count of accepted beats within the current pass.
  bit          m_active, m_stopping, m_done;
  int          m_beats, m_passes, m_count;
  bit          m_one;
  logic [31:0] m_base;

  s2mm_ring_controller dut (
    .aclk            (aclk),
    .areset          (areset),
    .cfg_base        (cfg_base),
    .cfg_burst_count (cfg_burst_count),
    .cfg_one_shot    (cfg_one_shot),
    .cfg_enable      (cfg_enable),
    .beat            (beat),
    .address         (address),
    .stream_gate     (stream_gate),
    .busy            (busy),
    .done            (done),
    .wr_pointer      (wr_pointer),
    .wrap_count      (wrap_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit counted, bend;
    if (areset) begin
      m_active = 0; m_stopping = 0; m_done = 0;
      m_beats = 0; m_passes = 0; m_count = 0; m_one = 0; m_base = '0;
      return;
    end
    if (m_done) begin
      if (!cfg_enable) m_done = 0;
    end else if (!m_active) begin
      if (cfg_enable && cfg_burst_count != 0) begin
        m_base = cfg_base; m_count = cfg_burst_count; m_one = cfg_one_shot;
        m_beats = 0; m_passes = 0; m_active = 1; m_stopping = 0;
      end
    end else begin
      counted = beat;
      bend    = 0;
      if (counted) begin
        m_beats++;
        bend = (m_beats % BL == 0);
        if (m_beats == m_count * BL) begin
          m_beats = 0;
          m_passes++;
          if (m_one) begin m_active = 0; m_done = 1; end
        end
      end
      if (m_active) begin
        if (m_stopping) begin
          if (bend) m_active = 0;
        end else if (!cfg_enable) begin
          if (bend || (!counted && m_beats % BL == 0)) m_active = 0;
          else m_stopping = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_addr;
    exp_addr = m_base + 32'((m_beats / BL) * BB);
    check("address",     address,           exp_addr);
    check("stream_gate", 32'(stream_gate),  32'(m_active));
    check("busy",        32'(busy),         32'(m_active));
    check("done",        32'(done),         32'(m_done));
    check("wr_pointer",  32'(wr_pointer),   32'(m_beats / BL));
    check("wrap_count",  32'(wrap_count),   32'(m_passes[15:0]));
  endtask

  // One clock: apply beat, advance model with the same inputs, compare just after the edge.
  task automatic tick(input logic b);
    beat = b;
    @(posedge aclk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int          gated;
    logic [31:0] exp_burst_addr [3];

    areset = 1'b1; cfg_base = '0; cfg_burst_count = '0; cfg_one_shot = 1'b0;
    cfg_enable = 1'b0; beat = 1'b0;
    tick(1'b0);
    tick(1'b1);
    check("reset_address", address, 32'h0);
    check("reset_gate",    32'(stream_gate), 32'h0);
    areset = 1'b0;

    // Continuous wrap over a three-burst ring.
    exp_burst_addr[0] = 32'h1000_0000;
    exp_burst_addr[1] = 32'h1000_0040;
    exp_burst_addr[2] = 32'h1000_0080;
    cfg_base = 32'h1000_0000; cfg_burst_count = 16'd3; cfg_enable = 1'b1;
    tick(1'b0);
    check("start_gate", 32'(stream_gate), 32'h1);
    for (int k = 0; k < 96; k++) begin
      if (k % BL == 0) check("burst_addr", address, exp_burst_addr[(k / BL) % 3]);
      tick(1'b1);
    end
    check("wrap_end_count", 32'(wrap_count), 32'd2);
    check("wrap_end_ptr",   32'(wr_pointer), 32'd0);
    check("wrap_end_addr",  address,         32'h1000_0000);

    // Mid-burst stop after five beats: exactly eleven more are accepted.
    for (int k = 0; k < 5; k++) tick(1'b1);
    cfg_enable = 1'b0;
    gated = 0;
    for (int k = 0; k < 20; k++) begin
      if (stream_gate) gated++;
      tick(1'b1);
    end
    check("stop_beats", 32'(gated), 32'd11);
    check("stop_gate",  32'(stream_gate), 32'h0);
    check("stop_busy",  32'(busy), 32'h0);

    // One-shot over two bursts with more beats offered than the ring holds.
    cfg_burst_count = 16'd2; cfg_one_shot = 1'b1; cfg_enable = 1'b1;
    tick(1'b0);
    gated = 0;
    for (int k = 0; k < 40; k++) begin
      if (stream_gate) gated++;
      tick(1'b1);
    end
    check("oneshot_beats", 32'(gated), 32'd32);
    check("oneshot_done",  32'(done), 32'h1);
    check("oneshot_gate",  32'(stream_gate), 32'h0);
    cfg_enable = 1'b0;
    tick(1'b0);
    check("oneshot_clear", 32'(done), 32'h0);

    // Zero-sized ring never starts.
    cfg_burst_count = 16'd0; cfg_one_shot = 1'b0; cfg_enable = 1'b1;
    for (int k = 0; k < 5; k++) tick(1'b1);
    check("invalid_busy", 32'(busy), 32'h0);
    check("invalid_gate", 32'(stream_gate), 32'h0);

    // Mid-run reset, then restart from a new base.
    cfg_base = 32'h2000_0400; cfg_burst_count = 16'd4;
    tick(1'b0);
    for (int k = 0; k < 21; k++) tick(1'b1);
    areset = 1'b1;
    tick(1'b1);
    check("rst_addr", address, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    areset = 1'b0;
    tick(1'b0);
    check("restart_addr", address, 32'h2000_0400);
    for (int k = 0; k < BL; k++) tick(1'b1);
    check("restart_next", address, 32'h2000_0440);

    // Randomized gaps, configs, enable toggles and the odd reset.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        cfg_base        = {$urandom_range(0, 32'h03FF_FFFF), 6'b0};
        cfg_burst_count = 16'($urandom_range(0, 5));
        cfg_one_shot    = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 59) == 0) cfg_enable = ~cfg_enable;
      areset = ($urandom_range(0, 999) == 0);
      tick(1'($urandom_range(0, 99) < 60));
    end
    if ($urandom_range(0, 0) == 0) areset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/s2mm_ring_controller.md
# s2mm_ring_controller

Sequencing controller for the stream-to-memory RAM writer. Generates the per-beat `address` the writer packs with each sample, advancing it one AXI burst at a time through a ring buffer in DDR. Gates the sample stream so that runs start and stop only on burst boundaries. Exposes write-pointer and wrap status to the register bank for software readout.

## Interface
- `ADDR_WIDTH`, 32: byte address width; matches the writer.
- `AXI_DATA_WIDTH`, 32: writer AXI data width; bytes per beat = `AXI_DATA_WIDTH/8`.
- `BURST_LENGTH`, 16: beats per burst; must equal the writer's fixed burst length; power of two.
- `aclk` in 1: system clock.
- `areset` in 1: synchronous, active-high reset.
- `cfg_base` in `ADDR_WIDTH`: ring base byte address; must be aligned to `BURST_BYTES` = `BURST_LENGTH*AXI_DATA_WIDTH/8`.
- `cfg_burst_count` in 16: ring size in bursts; 0 is invalid.
- `cfg_one_shot` in 1: 1 = stop after one full ring pass; 0 = wrap continuously.
- `cfg_enable` in 1: level; 1 = run; 0 = stop at the next burst boundary.
- `beat` in 1: beat accepted into the writer; connects to the writer's `reading` output.
- `address` out `ADDR_WIDTH`: current burst start address; goes to the writer's `address` input.
- `stream_gate` out 1: ANDed into the writer's `S_AXIS_tvalid` and `S_AXIS_tready`.
- `busy` out 1: state is RUN or FINISH.
- `done` out 1: one-shot pass complete.
- `wr_pointer` out 16: number of completed bursts in the current pass (0..`cfg_burst_count-1`).
- `wrap_count` out 16: completed ring passes, modulo 2^16.

## Operation
- **State machine:** IDLE, RUN, FINISH, DONE.
- **Internal registers:**
  - `beat_cnt`: log2(`BURST_LENGTH`) bits.
  - `burst_idx`: 16 bits; mirrored on `wr_pointer`.
  - Latched `base`, `count`, and `one_shot`.
- **Counted beats:** a beat counts only when `beat & stream_gate`. Beats with the gate low are ignored and change no state.
- **IDLE:**
  - When `cfg_enable=1` and `cfg_burst_count!=0`:
    - latch the config;
    - set `address <= cfg_base`, `beat_cnt <= 0`, `burst_idx <= 0`, `wrap_count <= 0`;
    - go to RUN.
  - When `cfg_burst_count=0`, the enable is ignored and the state stays IDLE.
- **Burst end:** a counted beat with `beat_cnt=BURST_LENGTH-1`.
- **RUN:**
  - Each counted beat increments `beat_cnt`, which wraps to 0 at burst end.
  - At burst end with `burst_idx=count-1` (ring end):
    - `burst_idx <= 0`, `address <= base`, `wrap_count <= wrap_count+1`;
    - if `one_shot`, go to DONE.
  - At any other burst end: `burst_idx <= burst_idx+1`, `address <= address+BURST_BYTES`. Arithmetic is modulo 2^`ADDR_WIDTH`.
  - `cfg_enable=0` with `beat_cnt=0` and no counted beat this cycle: go to IDLE.
  - `cfg_enable=0` otherwise: go to FINISH.
- **FINISH:**
  - Counting is the same as in RUN.
  - At burst end, go to IDLE, or to DONE if the ring end is reached with `one_shot`.
  - `cfg_enable` is ignored.
- **DONE:** hold all outputs. Go to IDLE when `cfg_enable=0`.
- **Simultaneous events:**
  - Ring end with `one_shot` and enable-drop in the same cycle: go to DONE.
  - Enable-drop at burst end in RUN: the burst is complete, so go to IDLE directly.
- **Reset:** `areset` mid-run aborts immediately. No drain; the writer is reset alongside.

## Timing
- **Reset values:**
  - `address=0`, `stream_gate=0`, `busy=0`, `done=0`, `wr_pointer=0`, `wrap_count=0`.
  - State IDLE, `beat_cnt=0`.
- **`stream_gate`:** decoded from the registered state (RUN or FINISH), with no combinational path from `beat`.
  - The last beat of a burst in FINISH is the final accepted beat.
  - The gate is 0 in the following cycle, so there is no overshoot.
- **`address`:**
  - Registered; changes in the cycle after the burst-end beat.
  - Every beat of a burst is tagged with the same address.
  - The first beat of the next burst sees the new value.
- **Start latency:** IDLE to RUN in 1 cycle. `stream_gate` is high in the cycle after `cfg_enable` is sampled high.
- **Other outputs:** `wr_pointer`, `wrap_count`, and `done` update on the same edge as `address`.
- **Throughput:** one beat per cycle sustained, with no bubbles at burst or ring boundaries.

## Test plan
- **Continuous wrap:** `cfg_base=0x1000_0000`, `cfg_burst_count=3`, continuous, 96 back-to-back beats.
  - `address` runs 0x1000_0000, 0x1000_0040, 0x1000_0080, then back to 0x1000_0000.
  - `wrap_count=2`, `wr_pointer=0` at the end.
- **Mid-burst stop:** drop `cfg_enable` after beat 5 of a burst.
  - Exactly 11 more beats are counted, then state is IDLE and `stream_gate=0`.
  - Further beats change nothing.
- **One-shot:** `cfg_burst_count=2`, one-shot, 40 beats offered.
  - 32 beats are counted; `done=1`, `stream_gate=0`.
  - Dropping `cfg_enable` returns to IDLE with `done=0`.
- **Invalid size:** `cfg_burst_count=0`, `cfg_enable=1`. State stays IDLE, `busy=0`, `stream_gate=0`.
- **Idle gaps:** random gaps between beats. Address advances only after each 16th counted beat.
- **Mid-run reset:** `areset` asserted mid-run for 1 cycle.
  - All outputs return to reset values the next cycle.
  - A restart begins at `cfg_base` with `beat_cnt=0`.
